// File: rtl/ftdi_pkg.sv
// Shared definitions for the FTDI transmit path: scheduler FSM encoding and the
// packet header byte (header insertion is built only with FTDI_TX_HEADER_EN).
package ftdi_pkg;

  localparam int TX_STATE_W  = 2;
  localparam int OUT_STATE_W = 3;

  typedef enum logic [TX_STATE_W-1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    STREAM  = 2'd2,
    RELEASE = 2'd3
  } txState_t;

  localparam logic [3:0] HEADER_NIBBLE = 4'hA;

  function automatic logic [7:0] headerByte(input logic [2:0] idx);
    return {HEADER_NIBBLE, 1'b0, idx};
  endfunction

endpackage

// File: rtl/ftdi_tx_scheduler_if.sv
// Requester, ring-RAM write and consumer signals of the TX scheduler.
// The scheduler connects through the slave modport; its environment uses master.
interface ftdi_tx_scheduler_if #(
  parameter int pDataWidth = 8,
  parameter int pMaxData   = 8,
  parameter int pNumReq    = 2
);

  localparam int cAddrW = $clog2(pMaxData);

  logic [pNumReq-1:0]            iReqValid;
  logic [pNumReq*pDataWidth-1:0] iReqData;
  logic [pNumReq-1:0]            iReqLast;
  logic [pNumReq-1:0]            oReqReady;
  logic [pNumReq-1:0]            oGrant;
  logic                          oRamWrEn;
  logic [cAddrW-1:0]             oRamWrAddr;
  logic [pDataWidth-1:0]         oRamWrData;
  logic                          iPacketRead;
  logic                          oPacketAvail;
  logic                          oFull;

  modport master (
    output iReqValid, iReqData, iReqLast, iPacketRead,
    input  oReqReady, oGrant, oRamWrEn, oRamWrAddr, oRamWrData, oPacketAvail, oFull
  );

  modport slave (
    input  iReqValid, iReqData, iReqLast, iPacketRead,
    output oReqReady, oGrant, oRamWrEn, oRamWrAddr, oRamWrData, oPacketAvail, oFull
  );

endinterface

// File: rtl/ftdi_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first requester above lastIdx (with wrap)
// wins; returns one-hot grant and its index.
module rr_arbiter #(
  parameter int pNumReq = 2,
  parameter int pIdxW   = 1
) (
  input  logic [pNumReq-1:0] req,
  input  logic [pIdxW-1:0]   lastIdx,
  output logic [pNumReq-1:0] grant,
  output logic [pIdxW-1:0]   grantIdx
);

  logic found;

  // Scan priority offsets 1..pNumReq from the previous winner.
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    for (int off = 1; off <= pNumReq; off++) begin
      for (int k = 0; k < pNumReq; k++) begin
        if (!found && req[k] && (k == ((int'(lastIdx) + off) % pNumReq))) begin
          found    = 1'b1;
          grant[k] = 1'b1;
          grantIdx = pIdxW'(k);
        end else begin
          found = found;
        end
      end
    end
  end

endmodule

// File: rtl/ftdi_tx_scheduler.sv
// Round-robin packet scheduler feeding the FTDI TX ring RAM and tracking occupancy.
// Define FTDI_TX_HEADER_EN to prefix every packet with a {4'hA,0,index} header byte.
module ftdi_tx_scheduler
  import ftdi_pkg::*;
#(
  parameter int pDataWidth = 8,
  parameter int pMaxData   = 8,
  parameter int pNumReq    = 2
) (
  input logic           iClk,
  input logic           iRst,
  ftdi_tx_scheduler_if.slave bus
);

  localparam int cAddrW = $clog2(pMaxData);
  localparam int cOccW  = cAddrW + 1;
  localparam int cIdxW  = $clog2(pNumReq);

  txState_t              stateR;
  txState_t              stateNext;
  logic [pNumReq-1:0]    grantR;
  logic [pNumReq-1:0]    grantNext;
  logic [pNumReq-1:0]    arbGrant;
  logic [pNumReq-1:0]    readyS;
  logic [cIdxW-1:0]      grantIdxR;
  logic [cIdxW-1:0]      grantIdxNext;
  logic [cIdxW-1:0]      ptrR;
  logic [cIdxW-1:0]      ptrNext;
  logic [cIdxW-1:0]      arbIdx;
  logic                  wrEnR;
  logic                  wrEnNext;
  logic [cAddrW-1:0]     wrAddrR;
  logic [cAddrW-1:0]     wrPtrR;
  logic [pDataWidth-1:0] wrDataR;
  logic [pDataWidth-1:0] wrDataNext;
  logic [pDataWidth-1:0] reqByteS;
  logic [cOccW-1:0]      occR;
  logic                  fullS;
  logic                  xferS;
  logic                  lastS;
  logic                  readS;

  rr_arbiter #(
    .pNumReq (pNumReq),
    .pIdxW   (cIdxW)
  ) uArb (
    .req      (bus.iReqValid),
    .lastIdx  (ptrR),
    .grant    (arbGrant),
    .grantIdx (arbIdx)
  );

  assign fullS  = (occR == cOccW'(pMaxData));
  assign readyS = ((stateR == STREAM) && !fullS) ? grantR : '0;
  assign xferS  = |(bus.iReqValid & readyS);
  // A read on an empty ring is dropped so the counter cannot underflow.
  assign readS  = bus.iPacketRead && (occR != '0);

  assign bus.oReqReady    = readyS;
  assign bus.oGrant       = grantR;
  assign bus.oRamWrEn     = wrEnR;
  assign bus.oRamWrAddr   = wrAddrR;
  assign bus.oRamWrData   = wrDataR;
  assign bus.oPacketAvail = (occR != '0);
  assign bus.oFull        = fullS;

  // Byte and last flag of the current owner.
  always_comb begin
    reqByteS = '0;
    lastS    = 1'b0;
    for (int k = 0; k < pNumReq; k++) begin
      if (grantR[k]) begin
        reqByteS = bus.iReqData[k*pDataWidth +: pDataWidth];
        lastS    = bus.iReqLast[k];
      end else begin
        reqByteS = reqByteS;
      end
    end
  end

  // Next-state and next-register values of the packet FSM.
  always_comb begin
    stateNext    = stateR;
    grantNext    = grantR;
    grantIdxNext = grantIdxR;
    ptrNext      = ptrR;
    wrEnNext     = 1'b0;
    wrDataNext   = wrDataR;
    case (stateR)
      IDLE: begin
        if (|bus.iReqValid) begin
          grantNext    = arbGrant;
          grantIdxNext = arbIdx;
`ifdef FTDI_TX_HEADER_EN
          stateNext    = HEADER;
`else
          stateNext    = STREAM;
`endif
        end else begin
          grantNext = '0;
        end
      end
`ifdef FTDI_TX_HEADER_EN
      HEADER: begin
        if (!fullS) begin
          wrEnNext   = 1'b1;
          wrDataNext = pDataWidth'(headerByte(3'(grantIdxR)));
          stateNext  = STREAM;
        end else begin
          stateNext = HEADER;
        end
      end
`endif
      STREAM: begin
        if (xferS) begin
          wrEnNext   = 1'b1;
          wrDataNext = reqByteS;
          stateNext  = lastS ? RELEASE : STREAM;
        end else begin
          stateNext = STREAM;
        end
      end
      RELEASE: begin
        ptrNext   = grantIdxR;
        grantNext = '0;
        stateNext = IDLE;
      end
      default: begin
        grantNext = '0;
        stateNext = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateR <= IDLE;
    end else begin
      stateR <= stateNext;
    end
  end

  // Grant, ring write port and occupancy registers; occupancy moves together
  // with the write strobe so oFull already blocks the handshake after the last slot.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      grantR    <= '0;
      grantIdxR <= '0;
      ptrR      <= cIdxW'(pNumReq - 1);
      wrEnR     <= 1'b0;
      wrDataR   <= '0;
      wrAddrR   <= '0;
      wrPtrR    <= '0;
      occR      <= '0;
    end else begin
      grantR    <= grantNext;
      grantIdxR <= grantIdxNext;
      ptrR      <= ptrNext;
      wrEnR     <= wrEnNext;
      wrDataR   <= wrDataNext;
      if (wrEnNext) begin
        wrAddrR <= wrPtrR;
        wrPtrR  <= wrPtrR + cAddrW'(1);
      end else begin
        wrAddrR <= wrAddrR;
        wrPtrR  <= wrPtrR;
      end
      case ({wrEnNext, readS})
        2'b10:   occR <= occR + cOccW'(1);
        2'b01:   occR <= occR - cOccW'(1);
        default: occR <= occR;
      endcase
    end
  end

endmodule
